// File: rtl/coin_collector.sv
// Coin consumer: per-lane claim FSMs, per-player scoring, win detection.
// Optional build macro COIN_COMBO_EN adds per-player combo counters (2 pts/lane inside window).

module coin_lane #(
  parameter logic [9:0] COIN_X     = 10'd64,
  parameter logic [9:0] HIT_RADIUS = 10'd16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       eval,
  input  logic       coin,
  input  logic [9:0] player_left,
  input  logic [9:0] player_right,
  output logic       own_left,
  output logic       own_right,
  output logic       clear
);
  typedef enum logic [1:0] {IDLE, LIVE, CLAIM} lane_state_e;

  lane_state_e state_q, state_d;
  logic [10:0] dist_l, dist_r;
  logic        hit, take, left_wins;

  always_comb begin
    dist_l = (player_left >= COIN_X) ? ({1'b0, player_left} - {1'b0, COIN_X})
                                     : ({1'b0, COIN_X} - {1'b0, player_left});
    dist_r = (player_right >= COIN_X) ? ({1'b0, player_right} - {1'b0, COIN_X})
                                      : ({1'b0, COIN_X} - {1'b0, player_right});
    hit       = (dist_l < {1'b0, HIT_RADIUS}) || (dist_r < {1'b0, HIT_RADIUS});
    left_wins = (dist_l <= dist_r);
    // A coin that vanished this cycle cannot be collected.
    take      = eval && coin && hit && (state_q == LIVE);
    own_left  = take && left_wins;
    own_right = take && !left_wins;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (coin) state_d = LIVE;
      LIVE:    if (take) state_d = CLAIM;
               else if (!coin) state_d = IDLE;
      CLAIM:   if (!coin) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  assign clear = (state_q == CLAIM);
endmodule

module coin_collector #(
  parameter logic [9:0] COIN_X0      = 10'd64,
  parameter logic [9:0] COIN_PITCH   = 10'd128,
  parameter logic [9:0] HIT_RADIUS   = 10'd16,
  parameter logic [7:0] WIN_SCORE    = 8'd20,
  parameter logic [7:0] COMBO_WINDOW = 8'd30
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       tick,
  input  logic       restart,
  input  logic [9:0] player_left,
  input  logic [9:0] player_right,
  input  logic [3:0] coin_out,
  output logic [3:0] coin_clear,
  output logic [7:0] score_left,
  output logic [7:0] score_right,
  output logic [1:0] collect_pulse,
  output logic       game_over,
  output logic [1:0] winner
);
  localparam int NUM_LANES = 4;

  logic [NUM_LANES-1:0] own_l, own_r;
  logic                 eval;
  logic [7:0]           score_left_q, score_left_d, score_right_q, score_right_d;
  logic [1:0]           pulse_q, pulse_d, winner_q, winner_d;
  logic                 game_over_q, game_over_d;
  logic [2:0]           cnt_l, cnt_r;
  logic [3:0]           pts_l, pts_r;
  logic [8:0]           sum_l, sum_r;
  logic [7:0]           sat_l, sat_r;

  // Restart wins over tick; a finished game stops all scoring.
  assign eval = tick && !restart && !game_over_q;

  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    localparam logic [9:0] LANE_X = COIN_X0 + 10'(i) * COIN_PITCH;
    coin_lane #(.COIN_X(LANE_X), .HIT_RADIUS(HIT_RADIUS)) u_lane (
      .clk(clk), .rst_n(rst_n), .eval(eval), .coin(coin_out[i]),
      .player_left(player_left), .player_right(player_right),
      .own_left(own_l[i]), .own_right(own_r[i]), .clear(coin_clear[i])
    );
  end

  function automatic logic [2:0] popcnt(input logic [NUM_LANES-1:0] v);
    popcnt = '0;
    for (int k = 0; k < NUM_LANES; k++) popcnt = popcnt + {2'b00, v[k]};
  endfunction

`ifdef COIN_COMBO_EN
  logic [7:0] since_l_q, since_l_d, since_r_q, since_r_d;

  always_comb begin
    since_l_d = since_l_q;
    since_r_d = since_r_q;
    if (restart) begin
      since_l_d = COMBO_WINDOW;
      since_r_d = COMBO_WINDOW;
    end else if (tick) begin
      if (|own_l) since_l_d = 8'd0;
      else if (since_l_q < COMBO_WINDOW) since_l_d = since_l_q + 8'd1;
      if (|own_r) since_r_d = 8'd0;
      else if (since_r_q < COMBO_WINDOW) since_r_d = since_r_q + 8'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      since_l_q <= COMBO_WINDOW;
      since_r_q <= COMBO_WINDOW;
    end else begin
      since_l_q <= since_l_d;
      since_r_q <= since_r_d;
    end
  end
`endif

  always_comb begin
    cnt_l = popcnt(own_l);
    cnt_r = popcnt(own_r);
`ifdef COIN_COMBO_EN
    pts_l = (since_l_q < COMBO_WINDOW) ? {cnt_l, 1'b0} : {1'b0, cnt_l};
    pts_r = (since_r_q < COMBO_WINDOW) ? {cnt_r, 1'b0} : {1'b0, cnt_r};
`else
    pts_l = {1'b0, cnt_l};
    pts_r = {1'b0, cnt_r};
`endif
    sum_l = {1'b0, score_left_q} + {5'b0, pts_l};
    sum_r = {1'b0, score_right_q} + {5'b0, pts_r};
    sat_l = sum_l[8] ? 8'hFF : sum_l[7:0];
    sat_r = sum_r[8] ? 8'hFF : sum_r[7:0];

    score_left_d  = score_left_q;
    score_right_d = score_right_q;
    game_over_d   = game_over_q;
    winner_d      = winner_q;
    pulse_d       = 2'b00;
    if (restart) begin
      score_left_d  = 8'd0;
      score_right_d = 8'd0;
      game_over_d   = 1'b0;
      winner_d      = 2'b00;
    end else if (eval) begin
      score_left_d  = sat_l;
      score_right_d = sat_r;
      pulse_d       = {|own_r, |own_l};
      if (sat_l >= WIN_SCORE || sat_r >= WIN_SCORE) begin
        game_over_d = 1'b1;
        winner_d    = {sat_r >= WIN_SCORE, sat_l >= WIN_SCORE};
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      score_left_q  <= 8'd0;
      score_right_q <= 8'd0;
      pulse_q       <= 2'b00;
      game_over_q   <= 1'b0;
      winner_q      <= 2'b00;
    end else begin
      score_left_q  <= score_left_d;
      score_right_q <= score_right_d;
      pulse_q       <= pulse_d;
      game_over_q   <= game_over_d;
      winner_q      <= winner_d;
    end
  end

  assign score_left    = score_left_q;
  assign score_right   = score_right_q;
  assign collect_pulse = pulse_q;
  assign game_over     = game_over_q;
  assign winner        = winner_q;
endmodule
